// File: rtl/reg_cmd_decoder.sv
// reg_cmd_decoder: framed byte-stream (header, data, checksum) write-command decoder.
// Drives the three-register bank's d/addr for exactly one cycle per good frame and
// parks addr at 2'b11 (no write) at all other times.
module reg_cmd_decoder #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] d,
    output logic [1:0] addr,
    output logic       busy,
    output logic [7:0] err_cnt
);

    localparam int unsigned GapW = $clog2(TIMEOUT + 1);
    localparam logic [GapW-1:0] GapMax = GapW'(TIMEOUT);
    localparam logic [1:0] AddrNone = 2'b11;

    typedef enum logic [1:0] {
        StIdle,
        StGotHdr,
        StGotData,
        StCommit
    } state_e;

    state_e          state_q, state_d;
    logic [1:0]      hdr_addr_q, hdr_addr_d;
    logic [7:0]      data_q, data_d;
    logic [GapW-1:0] gap_q, gap_d;
    logic [7:0]      d_q, d_d;
    logic [1:0]      addr_q, addr_d;
    logic [7:0]      err_q, err_d;

    logic            accept;
    logic            hdr_ok;
    logic            csum_ok;
    logic            gap_hit;
    logic            err_inc;
    logic [7:0]      hdr_full;

    // Handshake and status decode from the state register only.
    always_comb begin
        in_ready = (state_q != StCommit);
        busy     = (state_q != StIdle);
    end

    // Byte classification; the header is rebuilt from its only variable field.
    always_comb begin
        accept   = in_valid & in_ready;
        hdr_ok   = (in_data[7:4] == 4'hA) && (in_data[3:2] == 2'b00) &&
                   (in_data[1:0] != 2'b11);
        hdr_full = {4'hA, 2'b00, hdr_addr_q};
        csum_ok  = (in_data == (hdr_full ^ data_q));
        gap_hit  = (gap_q == GapMax);
    end

    // Next-state logic; an accept always takes priority over the gap limit.
    always_comb begin
        state_d    = state_q;
        hdr_addr_d = hdr_addr_q;
        data_d     = data_q;
        gap_d      = gap_q;
        d_d        = d_q;
        addr_d     = AddrNone;
        err_inc    = 1'b0;

        unique case (state_q)
            StIdle: begin
                gap_d = '0;
                if (accept) begin
                    if (hdr_ok) begin
                        hdr_addr_d = in_data[1:0];
                        state_d    = StGotHdr;
                    end else begin
                        err_inc = 1'b1;
                    end
                end
            end
            StGotHdr: begin
                if (accept) begin
                    data_d  = in_data;
                    gap_d   = '0;
                    state_d = StGotData;
                end else if (gap_hit) begin
                    gap_d   = '0;
                    err_inc = 1'b1;
                    state_d = StIdle;
                end else begin
                    gap_d = gap_q + GapW'(1);
                end
            end
            StGotData: begin
                if (accept) begin
                    gap_d = '0;
                    if (csum_ok) begin
                        addr_d  = hdr_addr_q;
                        d_d     = data_q;
                        state_d = StCommit;
                    end else begin
                        err_inc = 1'b1;
                        state_d = StIdle;
                    end
                end else if (gap_hit) begin
                    gap_d   = '0;
                    err_inc = 1'b1;
                    state_d = StIdle;
                end else begin
                    gap_d = gap_q + GapW'(1);
                end
            end
            StCommit: begin
                gap_d   = '0;
                state_d = StIdle;
            end
            default: begin
                gap_d   = '0;
                state_d = StIdle;
            end
        endcase

        err_d = (err_inc && (err_q != 8'hFF)) ? err_q + 8'd1 : err_q;
    end

    // State and registered outputs with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            hdr_addr_q <= 2'b00;
            data_q     <= 8'h00;
            gap_q      <= '0;
            d_q        <= 8'h00;
            addr_q     <= AddrNone;
            err_q      <= 8'h00;
        end else begin
            state_q    <= state_d;
            hdr_addr_q <= hdr_addr_d;
            data_q     <= data_d;
            gap_q      <= gap_d;
            d_q        <= d_d;
            addr_q     <= addr_d;
            err_q      <= err_d;
        end
    end

    assign d       = d_q;
    assign addr    = addr_q;
    assign err_cnt = err_q;

endmodule

// File: tb/tb_reg_cmd_decoder.sv
// Directed bench for reg_cmd_decoder with a behavioural model of the register bank.
module tb_reg_cmd_decoder;

    logic       clk;
    logic       rst_n;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] d;
    logic [1:0] addr;
    logic       busy;
    logic [7:0] err_cnt;

    int total;
    int bad;

    logic [7:0] bank [3];

    reg_cmd_decoder #(
        .TIMEOUT(8)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .in_data (in_data),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .d       (d),
        .addr    (addr),
        .busy    (busy),
        .err_cnt (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Downstream bank: captures d into q[addr] unless addr is the no-write code.
    always @(posedge clk) begin
        if (addr != 2'b11) bank[addr] <= d;
    end

    typedef struct {
        logic       rst_n;
        logic       vld;
        logic [7:0] data;
        logic [1:0] e_addr;
        logic [7:0] e_d;
        logic       e_busy;
        logic       e_rdy;
        logic [7:0] e_err;
    } vec_t;

    localparam int NVec = 20;
    vec_t vecs [NVec];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Drive inputs mid-cycle, then sample 1 time unit after the next rising edge.
    task automatic step(input logic r, input logic v, input logic [7:0] dat);
        @(negedge clk);
        rst_n    = r;
        in_valid = v;
        in_data  = dat;
        @(posedge clk);
        #1;
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        bank[0]  = 8'h00;
        bank[1]  = 8'h00;
        bank[2]  = 8'h00;

        //           rst  vld  data    addr   d      busy  rdy   err
        vecs[0]  = '{1'b0, 1'b0, 8'h00, 2'd3, 8'h00, 1'b0, 1'b1, 8'd0}; // reset
        vecs[1]  = '{1'b1, 1'b1, 8'hA1, 2'd3, 8'h00, 1'b1, 1'b1, 8'd0};
        vecs[2]  = '{1'b1, 1'b1, 8'h5C, 2'd3, 8'h00, 1'b1, 1'b1, 8'd0};
        vecs[3]  = '{1'b1, 1'b1, 8'hFD, 2'd1, 8'h5C, 1'b1, 1'b0, 8'd0}; // commit
        vecs[4]  = '{1'b1, 1'b1, 8'hA0, 2'd3, 8'h5C, 1'b0, 1'b1, 8'd0}; // held, not taken
        vecs[5]  = '{1'b1, 1'b1, 8'hA0, 2'd3, 8'h5C, 1'b1, 1'b1, 8'd0};
        vecs[6]  = '{1'b1, 1'b1, 8'h33, 2'd3, 8'h5C, 1'b1, 1'b1, 8'd0};
        vecs[7]  = '{1'b1, 1'b1, 8'h00, 2'd3, 8'h5C, 1'b0, 1'b1, 8'd1}; // bad checksum
        vecs[8]  = '{1'b1, 1'b1, 8'hA2, 2'd3, 8'h5C, 1'b1, 1'b1, 8'd1};
        vecs[9]  = '{1'b1, 1'b1, 8'h7E, 2'd3, 8'h5C, 1'b1, 1'b1, 8'd1};
        vecs[10] = '{1'b1, 1'b1, 8'hDC, 2'd2, 8'h7E, 1'b1, 1'b0, 8'd1}; // commit
        vecs[11] = '{1'b1, 1'b0, 8'h00, 2'd3, 8'h7E, 1'b0, 1'b1, 8'd1};
        vecs[12] = '{1'b1, 1'b1, 8'hA3, 2'd3, 8'h7E, 1'b0, 1'b1, 8'd2}; // addr 11 header
        vecs[13] = '{1'b1, 1'b1, 8'hB0, 2'd3, 8'h7E, 1'b0, 1'b1, 8'd3}; // wrong nibble
        vecs[14] = '{1'b1, 1'b1, 8'hA4, 2'd3, 8'h7E, 1'b0, 1'b1, 8'd4}; // H[3:2] set
        vecs[15] = '{1'b1, 1'b0, 8'h00, 2'd3, 8'h7E, 1'b0, 1'b1, 8'd4};
        vecs[16] = '{1'b1, 1'b1, 8'hA1, 2'd3, 8'h7E, 1'b1, 1'b1, 8'd4};
        vecs[17] = '{1'b1, 1'b1, 8'h44, 2'd3, 8'h7E, 1'b1, 1'b1, 8'd4};
        vecs[18] = '{1'b0, 1'b0, 8'h00, 2'd3, 8'h00, 1'b0, 1'b1, 8'd0}; // mid-frame reset
        vecs[19] = '{1'b1, 1'b1, 8'hE5, 2'd3, 8'h00, 1'b0, 1'b1, 8'd1}; // stale checksum

        for (int i = 0; i < NVec; i++) begin
            step(vecs[i].rst_n, vecs[i].vld, vecs[i].data);
            chk($sformatf("v%0d addr", i), 32'(addr), 32'(vecs[i].e_addr));
            chk($sformatf("v%0d d", i), 32'(d), 32'(vecs[i].e_d));
            chk($sformatf("v%0d busy", i), 32'(busy), 32'(vecs[i].e_busy));
            chk($sformatf("v%0d in_ready", i), 32'(in_ready), 32'(vecs[i].e_rdy));
            chk($sformatf("v%0d err_cnt", i), 32'(err_cnt), 32'(vecs[i].e_err));
        end
        chk("bank q0 after frames", 32'(bank[0]), 32'h00);
        chk("bank q1 after frames", 32'(bank[1]), 32'h5C);
        chk("bank q2 after frames", 32'(bank[2]), 32'h7E);

        // Timeout from GOT_HDR: counter reaches 8 after 8 idle edges, abort on the 9th.
        step(1'b1, 1'b1, 8'hA2);
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 8'h00);
        chk("hdr gap at limit busy", 32'(busy), 32'd1);
        chk("hdr gap at limit err", 32'(err_cnt), 32'd1);
        step(1'b1, 1'b0, 8'h00);
        chk("hdr timeout busy", 32'(busy), 32'd0);
        chk("hdr timeout err", 32'(err_cnt), 32'd2);
        chk("hdr timeout addr", 32'(addr), 32'd3);

        // Byte arriving in the limit cycle wins over the timeout.
        step(1'b1, 1'b1, 8'hA2);
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 8'h00);
        step(1'b1, 1'b1, 8'h11);
        chk("late data busy", 32'(busy), 32'd1);
        chk("late data err", 32'(err_cnt), 32'd2);
        step(1'b1, 1'b1, 8'hB3);
        chk("late frame addr", 32'(addr), 32'd2);
        chk("late frame d", 32'(d), 32'h11);
        chk("late frame in_ready", 32'(in_ready), 32'd0);
        step(1'b1, 1'b0, 8'h00);
        chk("late frame back idle addr", 32'(addr), 32'd3);
        chk("late frame back idle busy", 32'(busy), 32'd0);
        chk("bank q2 late frame", 32'(bank[2]), 32'h11);

        // Timeout from GOT_DATA.
        step(1'b1, 1'b1, 8'hA1);
        step(1'b1, 1'b1, 8'h22);
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 8'h00);
        chk("data gap at limit busy", 32'(busy), 32'd1);
        step(1'b1, 1'b0, 8'h00);
        chk("data timeout busy", 32'(busy), 32'd0);
        chk("data timeout err", 32'(err_cnt), 32'd3);
        chk("bank q1 untouched", 32'(bank[1]), 32'h5C);

        // Saturation: 300 rejected headers from err_cnt=3.
        for (int i = 0; i < 251; i++) step(1'b1, 1'b1, 8'h00);
        chk("err before saturation", 32'(err_cnt), 32'hFE);
        for (int i = 0; i < 49; i++) step(1'b1, 1'b1, 8'h00);
        chk("err saturated", 32'(err_cnt), 32'hFF);
        chk("busy after bad headers", 32'(busy), 32'd0);
        chk("addr after bad headers", 32'(addr), 32'd3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
